// File: rtl/ladner_pkg.sv
// ----------------------------------------------------------------------------
// ladner_pkg
// Shared definitions for the Ladner-Fischer sum/carry stage.
//   SLICE_W      : slice width carried per beat (matches the prefix network)
//   BEAT_FIELD_W : storage width of the beat index inside an output beat
//   state_t      : packet sequencing state {IDLE, BODY}
//   out_beat_t   : one registered result beat {sum, last, cout, ovf, beat}
// ----------------------------------------------------------------------------
package ladner_pkg;

    localparam int SLICE_W      = 4;
    localparam int BEAT_FIELD_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    typedef struct packed {
        logic [SLICE_W-1:0]      sum;
        logic                    last;
        logic                    cout;
        logic                    ovf;
        logic [BEAT_FIELD_W-1:0] beat;
    } out_beat_t;

endpackage

// File: rtl/ladner_slice_sum.sv
// ----------------------------------------------------------------------------
// ladner_slice_sum
// Combinational sum/carry resolution for one 4-bit slice, given the group
// generate/propagate terms from the prefix network and the slice carry-in.
//   go   in  : group generate, go[i] = G[i:0]
//   po   in  : group propagate, po[i] = P[i:0]
//   p    in  : bitwise propagate a^b
//   c0   in  : slice carry-in
//   sum  out : slice sum
//   cout out : slice carry-out
//   ovf  out : signed overflow (carry into MSB xor carry out of MSB)
// ----------------------------------------------------------------------------
module ladner_slice_sum
    import ladner_pkg::*;
(
    input  logic [SLICE_W-1:0] go,
    input  logic [SLICE_W-1:0] po,
    input  logic [SLICE_W-1:0] p,
    input  logic               c0,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               ovf
);

    logic [SLICE_W:0] c_s;

    // Every bit carry is resolved directly from the prefix terms and c0,
    // so there is no ripple through the slice.
    always_comb begin
        c_s    = {(SLICE_W + 1){1'b0}};
        c_s[0] = c0;
        for (int i = 1; i <= SLICE_W; i++) begin
            c_s[i] = go[i-1] | (po[i-1] & c0);
        end
        sum  = p ^ c_s[SLICE_W-1:0];
        cout = c_s[SLICE_W];
        ovf  = c_s[SLICE_W-1] ^ c_s[SLICE_W];
    end

endmodule

// File: rtl/ladner_sum_stage.sv
// ----------------------------------------------------------------------------
// ladner_sum_stage
// Registered sum/carry stage behind the 4-bit Ladner-Fischer prefix network.
// Wide operands arrive as multi-beat packets, LSB slice first; the carry is
// chained across beats and each result beat leaves one cycle after accept.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid / in_ready   : input handshake
//   in_first / in_last    : packet delimiters
//   in_go, in_po, in_p    : group generate, group propagate, bitwise a^b
//   cin                   : packet carry-in, used on the first beat only
//   out_valid / out_ready : output handshake
//   out_sum, out_cout     : slice sum and carry-out (final carry on last)
//   out_ovf               : signed overflow, meaningful with out_last
//   out_last, out_beat    : last flag and 0-based beat index
//   err                   : sticky protocol error, cleared only by reset
//
// Build option LADNER_SUM_SKID_EN: adds a second result register so that
// in_ready is a flop with no combinational path from out_ready. Without it
// a single output register is used and in_ready = !out_valid | out_ready.
// ----------------------------------------------------------------------------
module ladner_sum_stage #(
    parameter int SLICE_W   = 4,
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [SLICE_W-1:0] in_go,
    input  logic [SLICE_W-1:0] in_po,
    input  logic [SLICE_W-1:0] in_p,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_sum,
    output logic               out_last,
    output logic               out_cout,
    output logic               out_ovf,
    output logic [CNT_W-1:0]   out_beat,
    output logic               err
);

    import ladner_pkg::*;

    localparam logic [CNT_W-1:0] BEAT_LIM = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] BEAT_SAT = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             carry_r;
    logic [CNT_W-1:0] beat_r;
    logic             err_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             first_s;
    logic             proto_err_s;
    logic             sat_err_s;
    logic             c0_s;
    logic [CNT_W-1:0] idx_s;
    logic [CNT_W-1:0] idx_out_s;
    logic [CNT_W-1:0] beat_nxt_s;
    logic             carry_nxt_s;

    logic [SLICE_W-1:0] sum_s;
    logic               cout_s;
    logic               ovf_s;
    out_beat_t          beat_pkt_s;

    out_beat_t out_r;
    logic      out_valid_r;
    logic      unused_beat_hi_s;

    assign accept_s = in_valid & in_ready_s;

    ladner_slice_sum u_slice (
        .go   (in_go),
        .po   (in_po),
        .p    (in_p),
        .c0   (c0_s),
        .sum  (sum_s),
        .cout (cout_s),
        .ovf  (ovf_s)
    );

    // Packet sequencing: decide whether this beat starts a packet, pick the
    // slice carry-in, derive the beat index and the next carry/index/state.
    always_comb begin
        first_s     = 1'b1;
        proto_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                // Outside a packet every beat starts one; missing in_first is a violation.
                first_s     = 1'b1;
                proto_err_s = ~in_first;
            end
            BODY: begin
                // in_first inside a packet restarts it and is a violation.
                first_s     = in_first;
                proto_err_s = in_first;
            end
            default: begin
                first_s     = 1'b1;
                proto_err_s = 1'b0;
            end
        endcase

        c0_s  = first_s ? cin : carry_r;
        idx_s = first_s ? {CNT_W{1'b0}} : beat_r;

        // Over-long packet: keep processing, pin the reported index.
        if (idx_s >= BEAT_LIM) begin
            sat_err_s = 1'b1;
            idx_out_s = BEAT_SAT;
        end else begin
            sat_err_s = 1'b0;
            idx_out_s = idx_s;
        end

        if (in_last) begin
            state_nxt_s = IDLE;
            carry_nxt_s = 1'b0;
            beat_nxt_s  = {CNT_W{1'b0}};
        end else begin
            state_nxt_s = BODY;
            carry_nxt_s = cout_s;
            // beat_r parks at MAX_BEATS so every further beat keeps flagging.
            if (idx_s >= BEAT_LIM) begin
                beat_nxt_s = BEAT_LIM;
            end else begin
                beat_nxt_s = idx_s + CNT_ONE;
            end
        end

        beat_pkt_s.sum  = sum_s;
        beat_pkt_s.last = in_last;
        beat_pkt_s.cout = cout_s;
        beat_pkt_s.ovf  = ovf_s;
        beat_pkt_s.beat = {{(BEAT_FIELD_W - CNT_W){1'b0}}, idx_out_s};
    end

    // Packet state, chained carry, beat counter and sticky error advance on accept only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            carry_r <= 1'b0;
            beat_r  <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
        end else if (accept_s) begin
            state_r <= state_nxt_s;
            carry_r <= carry_nxt_s;
            beat_r  <= beat_nxt_s;
            err_r   <= err_r | proto_err_s | sat_err_s;
        end else begin
            state_r <= state_r;
            carry_r <= carry_r;
            beat_r  <= beat_r;
            err_r   <= err_r;
        end
    end

`ifdef LADNER_SUM_SKID_EN
    out_beat_t skid_r;
    logic      skid_valid_r;
    logic      in_ready_r;
    logic      out_free_s;

    assign out_free_s = ~out_valid_r | out_ready;
    assign in_ready_s = in_ready_r;

    // Output register plus skid entry; a beat accepted while the output is
    // stalled parks in the skid entry and drains ahead of any later beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r        <= {$bits(out_beat_t){1'b0}};
            out_valid_r  <= 1'b0;
            skid_r       <= {$bits(out_beat_t){1'b0}};
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (out_free_s) begin
            if (skid_valid_r) begin
                out_r        <= skid_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
                in_ready_r   <= 1'b1;
            end else begin
                out_valid_r <= accept_s;
                if (accept_s) begin
                    out_r <= beat_pkt_s;
                end else begin
                    out_r <= out_r;
                end
                in_ready_r <= 1'b1;
            end
        end else begin
            if (accept_s) begin
                skid_r       <= beat_pkt_s;
                skid_valid_r <= 1'b1;
                in_ready_r   <= 1'b0;
            end else begin
                in_ready_r <= ~skid_valid_r;
            end
        end
    end
`else
    assign in_ready_s = ~out_valid_r | out_ready;

    // Single output register; it only changes when the consumer frees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= {$bits(out_beat_t){1'b0}};
            out_valid_r <= 1'b0;
        end else if (in_ready_s) begin
            out_valid_r <= in_valid;
            if (accept_s) begin
                out_r <= beat_pkt_s;
            end else begin
                out_r <= out_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
            out_r       <= out_r;
        end
    end
`endif

    assign unused_beat_hi_s = ^out_r.beat[BEAT_FIELD_W-1:CNT_W];

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_sum   = out_r.sum;
    assign out_last  = out_r.last;
    assign out_cout  = out_r.cout;
    assign out_ovf   = out_r.ovf;
    assign out_beat  = out_r.beat[CNT_W-1:0];
    assign err       = err_r;

endmodule

// File: tb/tb_ladner_sum_stage.sv
// ----------------------------------------------------------------------------
// tb_ladner_sum_stage
// Drives slices built from plain 4-bit operands and predicts every result
// beat from integer addition (a + b + carry), packet rules and a queue.
// ----------------------------------------------------------------------------
module tb_ladner_sum_stage;

    localparam int MAXB = 8;
    localparam int CW   = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_first;
    logic          in_last;
    logic [3:0]    in_go;
    logic [3:0]    in_po;
    logic [3:0]    in_p;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_sum;
    logic          out_last;
    logic          out_cout;
    logic          out_ovf;
    logic [CW-1:0] out_beat;
    logic          err;

    typedef struct {
        int sum;
        int last;
        int cout;
        int ovf;
        int beat;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] cur_a, cur_b;
    logic       cur_first, cur_last, cur_cin;
    logic       accepted;

    // reference packet state
    logic m_in_pkt;
    int   m_carry;
    int   m_idx;
    logic m_err;

    logic prev_stall, prev_acc_nostall;
    int   held_sum, held_last, held_cout, held_ovf, held_beat;
    int   stall_cnt;
    logic rand_ready;

    ladner_sum_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_go     (in_go),
        .in_po     (in_po),
        .in_p      (in_p),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_beat  (out_beat),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        assert (got === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // G[i:0]: carry out of bit i when adding the low i+1 bits with no carry-in
    function automatic logic [3:0] gen_go(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            int m;
            m = (1 << (i + 1)) - 1;
            r[i] = (((int'(a) & m) + (int'(b) & m)) >> (i + 1)) != 0;
        end
        return r;
    endfunction

    // P[i:0]: every bit 0..i propagates
    function automatic logic [3:0] gen_po(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            int m;
            m = (1 << (i + 1)) - 1;
            r[i] = ((int'(a ^ b) & m) == m);
        end
        return r;
    endfunction

    task automatic do_cycle();
        logic acc;
        exp_t e;
        int   first, c0, idx, s;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else if (rand_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("err_flag", err, m_err);
`ifndef LADNER_SUM_SKID_EN
        chk("in_ready_comb", in_ready, !out_valid || out_ready);
`endif
        if (prev_acc_nostall) chk("latency1_valid", out_valid, 1);
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum",   out_sum,   held_sum);
            chk("hold_last",  out_last,  held_last);
            chk("hold_cout",  out_cout,  held_cout);
            chk("hold_ovf",   out_ovf,   held_ovf);
            chk("hold_beat",  out_beat,  held_beat);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_beat", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_sum",  out_sum,  e.sum);
                chk("out_last", out_last, e.last);
                chk("out_cout", out_cout, e.cout);
                chk("out_ovf",  out_ovf,  e.ovf);
                chk("out_beat", out_beat, e.beat);
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            accepted = 1'b1;
            first = (!m_in_pkt || cur_first) ? 1 : 0;
            if (m_in_pkt == cur_first) m_err = 1'b1;
            c0  = first ? int'(cur_cin) : m_carry;
            idx = first ? 0 : m_idx;
            if (idx >= MAXB) m_err = 1'b1;
            s = int'(cur_a) + int'(cur_b) + c0;
            e.sum  = s % 16;
            e.cout = s / 16;
            e.ovf  = (cur_a[3] == cur_b[3]) && (((s >> 3) & 1) != int'(cur_a[3]));
            e.last = int'(cur_last);
            e.beat = (idx >= MAXB) ? MAXB - 1 : idx;
            exp_q.push_back(e);
            if (cur_last) begin
                m_in_pkt = 1'b0;
                m_carry  = 0;
                m_idx    = 0;
            end else begin
                m_in_pkt = 1'b1;
                m_carry  = e.cout;
                m_idx    = idx + 1;
            end
        end
        prev_stall       = out_valid && !out_ready;
        prev_acc_nostall = acc && !(out_valid && !out_ready);
        held_sum  = int'(out_sum);
        held_last = int'(out_last);
        held_cout = int'(out_cout);
        held_ovf  = int'(out_ovf);
        held_beat = int'(out_beat);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b,
                        input logic first, input logic last, input logic c);
        int guard;
        guard     = 0;
        cur_a     = a;
        cur_b     = b;
        cur_first = first;
        cur_last  = last;
        cur_cin   = c;
        in_go     = gen_go(a, b);
        in_po     = gen_po(a, b);
        in_p      = a ^ b;
        in_first  = first;
        in_last   = last;
        cin       = c;
        in_valid  = 1'b1;
        accepted  = 1'b0;
        while (!accepted && guard < 50) begin
            do_cycle();
            guard++;
        end
        chk("accept_timeout", accepted, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum",   out_sum,   0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_out_cout",  out_cout,  0);
        chk("rst_out_ovf",   out_ovf,   0);
        chk("rst_out_beat",  out_beat,  0);
        chk("rst_err",       err,       0);
        exp_q.delete();
        m_in_pkt         = 1'b0;
        m_carry          = 0;
        m_idx            = 0;
        m_err            = 1'b0;
        prev_stall       = 1'b0;
        prev_acc_nostall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        in_valid  = 1'b0;
        stall_cnt = 0;
        rand_ready = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && guard < 60) begin
            do_cycle();
            guard++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_first   = 1'b0;
        in_last    = 1'b0;
        in_go      = 4'h0;
        in_po      = 4'h0;
        in_p       = 4'h0;
        cin        = 1'b0;
        out_ready  = 1'b1;
        stall_cnt  = 0;
        rand_ready = 1'b0;
        accepted   = 1'b0;
        cur_a = 4'h0; cur_b = 4'h0; cur_first = 1'b0; cur_last = 1'b0; cur_cin = 1'b0;
        #1;
        do_reset();
        idle(1);

        // 0x5A + 0x3C as two slices
        send(4'hA, 4'hC, 1'b1, 1'b0, 1'b0);
        send(4'h5, 4'h3, 1'b0, 1'b1, 1'b0);
        idle(2);
        // 0xF + 0x1 single beat, without and with carry-in
        send(4'hF, 4'h1, 1'b1, 1'b1, 1'b0);
        send(4'hF, 4'h1, 1'b1, 1'b1, 1'b1);
        idle(2);

        // backpressure for 3 cycles inside a 4-beat stream
        send(4'h9, 4'h8, 1'b1, 1'b0, 1'b1);
        stall_cnt = 3;
        send(4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        send(4'h7, 4'h9, 1'b0, 1'b0, 1'b0);
        send(4'h6, 4'h6, 1'b0, 1'b1, 1'b0);
        drain();

        // beat without in_first from IDLE, then a restart inside a packet
        send(4'h3, 4'h4, 1'b0, 1'b1, 1'b1);
        send(4'h8, 4'h8, 1'b1, 1'b0, 1'b0);
        send(4'h2, 4'h2, 1'b1, 1'b1, 1'b0);
        drain();

        // 9-beat packet: index pins at 7 and err rises
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send(4'(i + 7), 4'hB, (i == 0), (i == 8), 1'b1);
        end
        drain();

        // reset after beat 1 of 4, stale carry = 1, new packet uses cin = 0
        do_reset();
        send(4'h3, 4'h4, 1'b1, 1'b0, 1'b0);
        send(4'hF, 4'h1, 1'b0, 1'b0, 1'b0);
        do_reset();
        send(4'h7, 4'h8, 1'b1, 1'b1, 1'b0);
        drain();

        // random well-formed packets under random backpressure and gaps
        do_reset();
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, MAXB);
            for (int i = 0; i < len; i++) begin
                send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     (i == 0), (i == len - 1), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 4) == 0) idle(1);
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
